pwm_output_stage: RTL and testbench

Output stage fed by the SPI register block. It takes the five control registers (output enables, PWM enables, duty cycle) and drives the 16 chip outputs, either static-high, low, or PWM-modulated. An 8-bit PWM counter advances once every PRESCALE clocks, and the duty cycle is double-buffered so that an SPI write never produces a runt pulse mid-period.

---
 rtl/pwm_output_stage.sv | 97 +++++++++
 tb/tb_pwm_output_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_stage.sv
// 16-channel output stage: each channel is off, static-high or PWM-modulated.
// The duty cycle is double-buffered at the period wrap so an SPI write never produces a runt pulse.
module pwm_output_stage #(
   parameter int PRESCALE = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] out_7_0,
   output logic [7:0] out_15_8,
   output logic       period_start
);
   localparam int              NUM_LANES = 16;
   localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_MAX   = PW'(PRESCALE - 1);

   typedef struct packed {
      logic [NUM_LANES-1:0] en_out;
      logic [NUM_LANES-1:0] en_pwm;
   } ch_cfg_t;

   logic [PW-1:0]        r_pre_cnt;
   logic [7:0]           r_pwm_cnt;
   logic [7:0]           r_duty_sh;
   logic                 r_period_start;
   logic                 w_tick;
   logic                 w_wrap;
   logic [7:0]           w_cnt_nxt;
   logic [7:0]           w_duty_nxt;
   logic                 w_pwm_lvl;
   ch_cfg_t              w_cfg;
   logic [NUM_LANES-1:0] w_out;

   assign w_tick     = (r_pre_cnt == PRE_MAX);
   assign w_wrap     = w_tick && (r_pwm_cnt == 8'hFF);
   assign w_cnt_nxt  = w_tick ? r_pwm_cnt + 8'd1 : r_pwm_cnt;
   assign w_duty_nxt = w_wrap ? pwm_duty_cycle : r_duty_sh;

   // Level is taken from next-state counter/shadow so the lane flops rise
   // on the same cycle as period_start.
   assign w_pwm_lvl = (w_duty_nxt == 8'hFF) || (w_cnt_nxt < w_duty_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt      <= '0;
         r_pwm_cnt      <= 8'h00;
         r_duty_sh      <= 8'h00;
         r_period_start <= 1'b0;
      end else begin
         r_pre_cnt      <= w_tick ? '0 : r_pre_cnt + PW'(1);
         r_pwm_cnt      <= w_cnt_nxt;
         r_duty_sh      <= w_duty_nxt;
         r_period_start <= w_wrap;
      end
   end

   assign w_cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign w_cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pwm_lane u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_en_out  (w_cfg.en_out[gi]),
         .i_en_pwm  (w_cfg.en_pwm[gi]),
         .i_pwm_lvl (w_pwm_lvl),
         .o_out     (w_out[gi])
      );
   end

   assign out_7_0      = w_out[7:0];
   assign out_15_8     = w_out[15:8];
   assign period_start = r_period_start;
endmodule

// One output channel: disabled -> 0, enabled static -> 1, enabled PWM -> level.
module pwm_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en_out,
   input  logic i_en_pwm,
   input  logic i_pwm_lvl,
   output logic o_out
);
   logic r_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= 1'b0;
      else        r_out <= i_en_out & (~i_en_pwm | i_pwm_lvl);
   end

   assign o_out = r_out;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: scenario tasks plus a cycle-count reference model
// derived from edges-since-reset arithmetic; a second instance covers PRESCALE=1.
module tb_pwm_output_stage;
   localparam int P   = 13;
   localparam int PER = 256 * P;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty   = '0;
   logic [7:0]  o_lo, o_hi;
   logic        ps;
   logic [15:0] q_en   = 16'hFFFF;
   logic [7:0]  q_duty = 8'h03;
   logic [7:0]  q_lo, q_hi;
   logic        q_ps;
   logic [15:0] dout, qout;
   int          checks = 0;
   int          errors = 0;

   assign dout = {o_hi, o_lo};
   assign qout = {q_hi, q_lo};

   always #5 clk = ~clk;

   pwm_output_stage #(.PRESCALE(P)) dut (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty),
      .out_7_0(o_lo), .out_15_8(o_hi), .period_start(ps)
   );

   pwm_output_stage #(.PRESCALE(1)) dut_p1 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(q_en[7:0]), .en_reg_out_15_8(q_en[15:8]),
      .en_reg_pwm_7_0(q_en[7:0]), .en_reg_pwm_15_8(q_en[15:8]),
      .pwm_duty_cycle(q_duty),
      .out_7_0(q_lo), .out_15_8(q_hi), .period_start(q_ps)
   );

   // Model: m_n counts edges since reset release; the counter step is m_n/P mod 256,
   // and the duty is latched whenever m_n reaches a multiple of the period.
   int          m_n    = 0;
   logic [7:0]  m_duty = '0;
   logic [15:0] m_eo   = '0;
   logic [15:0] m_ep   = '0;
   logic        m_lvl;
   logic [15:0] exp_out;
   logic        exp_ps;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n <= 0; m_duty <= '0; m_eo <= '0; m_ep <= '0;
      end else begin
         m_n <= m_n + 1;
         if ((m_n + 1) % PER == 0) m_duty <= duty;
         m_eo <= en_out;
         m_ep <= en_pwm;
      end
   end

   assign m_lvl   = (m_duty == 8'hFF) || ((m_n / P) % 256 < int'(m_duty));
   assign exp_out = m_eo & (~m_ep | {16{m_lvl}});
   assign exp_ps  = (m_n > 0) && (m_n % PER == 0);

   task automatic wait_ps(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (ps === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      int first;
      bit bad;
      rst_n = 1'b0; en_out = '1; en_pwm = '1; duty = 8'hFF;
      repeat (3) @(negedge clk);
      checks++;
      if (dout !== 16'h0 || ps !== 1'b0) begin
         errors++; $display("FAIL reset_hold out=%h ps=%b expected 0000 0", dout, ps);
      end
      rst_n = 1'b1;
      first = -1; bad = 1'b0;
      for (int e = 1; e <= PER + 4 && !bad; e++) begin
         @(negedge clk);
         if (ps === 1'b1 && first < 0) first = e;
         checks++;
         if (e < PER && dout !== 16'h0) begin
            bad = 1'b1; errors++; $display("FAIL reset_low edge=%0d out=%h expected 0000", e, dout);
         end else if (dout !== exp_out || ps !== exp_ps) begin
            bad = 1'b1; errors++;
            $display("FAIL reset_model edge=%0d out=%h ps=%b expected %h %b", e, dout, ps, exp_out, exp_ps);
         end
      end
      checks++;
      if (first != PER) begin
         errors++; $display("FAIL reset_first_ps edge=%0d expected %0d", first, PER);
      end
   endtask

   task automatic test_static;
      logic [15:0] pat;
      en_pwm = '0; en_out = 16'hA5C3;
      #1;
      checks++;
      if (dout !== exp_out) begin
         errors++; $display("FAIL static_no_early out=%h expected %h", dout, exp_out);
      end
      @(negedge clk);
      checks++;
      if (dout !== 16'hA5C3) begin errors++; $display("FAIL static_a5c3 out=%h expected a5c3", dout); end
      en_out = 16'h0000;
      @(negedge clk);
      checks++;
      if (dout !== 16'h0000) begin errors++; $display("FAIL static_off out=%h expected 0000", dout); end
      for (int i = 0; i < 6; i++) begin
         pat = 16'($urandom);
         en_out = pat;
         @(negedge clk);
         checks++;
         if (dout !== pat) begin errors++; $display("FAIL static_rand out=%h expected %h", dout, pat); end
      end
   endtask

   task automatic test_duty80;
      int hi, lo;
      bit ok, bad;
      en_out = '1; en_pwm = '1; duty = 8'h80; bad = 1'b0;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL duty80_wait ps=%b expected 1", ps); end
      for (int p = 0; p < 2; p++) begin
         hi = 0; lo = 0;
         for (int c = 0; c < PER; c++) begin
            if (dout === 16'hFFFF) hi++; else if (dout === 16'h0000) lo++;
            if (!bad) begin
               checks++;
               if (dout !== exp_out || ps !== exp_ps) begin
                  bad = 1'b1; errors++;
                  $display("FAIL duty80_model c=%0d out=%h ps=%b expected %h %b", c, dout, ps, exp_out, exp_ps);
               end
            end
            @(negedge clk);
         end
         checks++;
         if (hi != 1664) begin errors++; $display("FAIL duty80_high cycles=%0d expected 1664", hi); end
         checks++;
         if (lo != 1664) begin errors++; $display("FAIL duty80_low cycles=%0d expected 1664", lo); end
         checks++;
         if (ps !== 1'b1) begin errors++; $display("FAIL duty80_period ps=%b expected 1 after 3328", ps); end
      end
   endtask

   task automatic test_extremes;
      int hi0;
      bit ok, bad;
      en_out = '1; en_pwm = '1; duty = 8'h00; bad = 1'b0;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ext_wait0 ps=%b expected 1", ps); end
      for (int c = 0; c < PER && !bad; c++) begin
         checks++;
         if (dout !== 16'h0000) begin bad = 1'b1; errors++; $display("FAIL ext_duty00 c=%0d out=%h expected 0000", c, dout); end
         @(negedge clk);
      end
      duty = 8'hFF; bad = 1'b0;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ext_waitff ps=%b expected 1", ps); end
      for (int c = 0; c < 2 * PER && !bad; c++) begin
         checks++;
         if (dout !== 16'hFFFF) begin bad = 1'b1; errors++; $display("FAIL ext_dutyff c=%0d out=%h expected ffff", c, dout); end
         @(negedge clk);
      end
      en_pwm = 16'h0001; duty = 8'h80; bad = 1'b0; hi0 = 0;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ext_wait1 ps=%b expected 1", ps); end
      for (int c = 0; c < PER && !bad; c++) begin
         if (dout[0] === 1'b1) hi0++;
         checks++;
         if (dout[15:1] !== 15'h7FFF || dout[0] !== exp_out[0]) begin
            bad = 1'b1; errors++; $display("FAIL ext_ch0 c=%0d out=%h expected %h", c, dout, {15'h7FFF, exp_out[0]});
         end
         @(negedge clk);
      end
      checks++;
      if (hi0 != 1664) begin errors++; $display("FAIL ext_ch0_high cycles=%0d expected 1664", hi0); end
   endtask

   task automatic test_mid_change;
      int hi[3];
      int want[3];
      bit ok, bad;
      want[0] = 64 * P; want[1] = 192 * P; want[2] = 32 * P;
      hi[0] = 0; hi[1] = 0; hi[2] = 0;
      en_out = '1; en_pwm = '1; duty = 8'h40; bad = 1'b0;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_wait ps=%b expected 1", ps); end
      for (int c = 0; c < 3 * PER; c++) begin
         if (c == 32 * P) duty = 8'hC0;
         if (c == 2 * PER - 1) duty = 8'h20;
         if (dout === 16'hFFFF) hi[c / PER]++;
         if (c % PER == 0) begin
            checks++;
            if (ps !== 1'b1) begin errors++; $display("FAIL mid_ps c=%0d ps=%b expected 1", c, ps); end
         end
         if (!bad) begin
            checks++;
            if (dout !== exp_out) begin
               bad = 1'b1; errors++; $display("FAIL mid_model c=%0d out=%h expected %h", c, dout, exp_out);
            end
         end
         @(negedge clk);
      end
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (hi[p] != want[p]) begin
            errors++; $display("FAIL mid_high period=%0d cycles=%0d expected %0d", p, hi[p], want[p]);
         end
      end
   endtask

   task automatic test_random;
      int len;
      bit bad;
      bad = 1'b0;
      for (int s = 0; s < 60; s++) begin
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       duty = 8'h00;
            1:       duty = 8'hFF;
            default: duty = 8'($urandom);
         endcase
         len = $urandom_range(50, 400);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (!bad) begin
               checks++;
               if (dout !== exp_out || ps !== exp_ps) begin
                  bad = 1'b1; errors++;
                  $display("FAIL rand_model seg=%0d out=%h ps=%b expected %h %b", s, dout, ps, exp_out, exp_ps);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int first;
      bit ok, bad;
      en_out = '1; en_pwm = '1; duty = 8'h80;
      wait_ps(2 * PER, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_wait ps=%b expected 1", ps); end
      repeat (8'h50 * P + 5) @(negedge clk);
      checks++;
      if (dout !== 16'hFFFF) begin errors++; $display("FAIL rstmid_pre out=%h expected ffff", dout); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== 16'h0000 || ps !== 1'b0) begin
         errors++; $display("FAIL rstmid_async out=%h ps=%b expected 0000 0", dout, ps);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = -1; bad = 1'b0;
      for (int e = 1; e <= PER + 2; e++) begin
         @(negedge clk);
         if (ps === 1'b1 && first < 0) first = e;
         if (!bad) begin
            checks++;
            if ((e < PER && dout !== 16'h0) || dout !== exp_out) begin
               bad = 1'b1; errors++; $display("FAIL rstmid_model edge=%0d out=%h expected %h", e, dout, exp_out);
            end
         end
      end
      checks++;
      if (first != PER) begin errors++; $display("FAIL rstmid_first_ps edge=%0d expected %0d", first, PER); end
   endtask

   task automatic test_prescale1;
      int hi, lo;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (q_ps === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL p1_wait ps=%b expected 1", q_ps); end
      for (int p = 0; p < 2; p++) begin
         hi = 0; lo = 0;
         checks++;
         if (qout !== 16'hFFFF) begin errors++; $display("FAIL p1_start out=%h expected ffff", qout); end
         for (int c = 0; c < 256; c++) begin
            if (qout === 16'hFFFF && lo == 0) hi++;
            else if (qout === 16'h0000) lo++;
            @(negedge clk);
         end
         checks++;
         if (hi != 3) begin errors++; $display("FAIL p1_high cycles=%0d expected 3", hi); end
         checks++;
         if (lo != 253) begin errors++; $display("FAIL p1_low cycles=%0d expected 253", lo); end
         checks++;
         if (q_ps !== 1'b1) begin errors++; $display("FAIL p1_period ps=%b expected 1 after 256", q_ps); end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_duty80();
      test_extremes();
      test_mid_change();
      test_random();
      test_reset_mid();
      test_prescale1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
